adpcm_main_mul_pipe_sat: RTL and testbench

//  Parametrised pipelined signed multiplier for the adpcm_main datapath (quantiser/predictor MACs).

---
 rtl/adpcm_main_mul_pipe_sat.sv | 111 +++++++++++
 tb/tb_adpcm_main_mul_pipe_sat.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_main_mul_pipe_sat.sv
// Pipelined signed multiplier for the adpcm_main MAC path: configurable depth, valid/ready
// flow control, optional scaling shift with round-half-up, saturation and overflow flag.
module adpcm_main_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 16,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 46,
  parameter int SHIFT      = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PW  = din0_WIDTH + din1_WIDTH;
  // One guard bit above the product so the rounding add cannot wrap; also wide enough to
  // hold the dout range limits when dout is wider than the product.
  localparam int EW  = (PW + 1 > dout_WIDTH + 1) ? PW + 1 : dout_WIDTH + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND_ADD =
    (ROUND != 0 && SHIFT != 0) ? ({{(EW-1){1'b0}}, 1'b1} << RSH) : '0;
  localparam logic signed [EW-1:0] DMAX = {{(EW-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] DMIN = ~DMAX;

  logic                  stall;
  logic                  advance;
  logic signed [PW-1:0]  mul_prod;
  logic signed [PW-1:0]  tail_prod;
  logic                  tail_valid;
  logic signed [EW-1:0]  sum_ext;
  logic signed [EW-1:0]  res_ext;
  logic                  res_ovf;
  logic [dout_WIDTH-1:0] res_dout;
  logic                  out_valid_reg;
  logic [dout_WIDTH-1:0] dout_reg;
  logic                  ovf_reg;

  assign stall    = !ce || (out_valid_reg && !out_ready);
  assign advance  = !stall;
  assign in_ready = !stall;
  assign mul_prod = PW'($signed(din0)) * PW'($signed(din1));

  generate
    if (NUM_STAGE == 1) begin : g_comb
      assign tail_prod  = mul_prod;
      assign tail_valid = in_valid;
    end else begin : g_pipe
      // Product registers; the whole chain moves as one unit so bubbles stay in place.
      logic signed [PW-1:0] prod_reg [NUM_STAGE-1];
      logic [NUM_STAGE-2:0] pvalid_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < NUM_STAGE - 1; i++) begin
            prod_reg[i]   <= '0;
            pvalid_reg[i] <= 1'b0;
          end
        end else if (advance) begin
          prod_reg[0]   <= mul_prod;
          pvalid_reg[0] <= in_valid;
          for (int i = 1; i < NUM_STAGE - 1; i++) begin
            prod_reg[i]   <= prod_reg[i-1];
            pvalid_reg[i] <= pvalid_reg[i-1];
          end
        end
      end

      assign tail_prod  = prod_reg[NUM_STAGE-2];
      assign tail_valid = pvalid_reg[NUM_STAGE-2];
    end
  endgenerate

  always_comb begin
    sum_ext = EW'(tail_prod) + RND_ADD;
    res_ext = sum_ext >>> SHIFT;
    res_ovf = (res_ext > DMAX) || (res_ext < DMIN);
    if (SATURATE != 0 && res_ovf) begin
      res_dout = res_ext[EW-1] ? DMIN[dout_WIDTH-1:0] : DMAX[dout_WIDTH-1:0];
    end else begin
      res_dout = res_ext[dout_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      dout_reg      <= '0;
      ovf_reg       <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= tail_valid;
      dout_reg      <= res_dout;
      ovf_reg       <= res_ovf;
    end
  end

  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_adpcm_main_mul_pipe_sat.sv
// Bench for adpcm_main_mul_pipe_sat: several parameter sets share one stimulus stream, each
// checked against an integer-arithmetic scoreboard plus hand-computed literal results.
module tb_adpcm_main_mul_pipe_sat;

  localparam int NCFG = 7;
  localparam int NS_T  [NCFG] = '{3, 3, 3, 3, 3, 1, 8};
  localparam int DW_T  [NCFG] = '{46, 16, 16, 46, 46, 20, 24};
  localparam int SH_T  [NCFG] = '{0, 0, 0, 4, 4, 3, 8};
  localparam int RD_T  [NCFG] = '{0, 0, 0, 1, 0, 1, 1};
  localparam int SAT_T [NCFG] = '{0, 1, 0, 0, 0, 1, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] din0 = '0;
  logic [31:0] din1 = '0;

  wire signed [63:0] dout_x [NCFG];
  wire [NCFG-1:0]    ovf_x;
  wire [NCFG-1:0]    out_valid_x;
  wire [NCFG-1:0]    in_ready_x;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint aq [NCFG][$];
  longint bq [NCFG][$];
  longint got_d [NCFG];
  bit     got_o [NCFG];
  int     got_lat [NCFG];

  always #5 clk = ~clk;

  // Expected result from plain integer arithmetic on the operands.
  function automatic void model(input int g, input longint a, input longint b,
                                output longint d, output bit o);
    longint p, r, mx, mn;
    p = a * b;
    if (RD_T[g] != 0 && SH_T[g] > 0) p = p + (longint'(1) <<< (SH_T[g] - 1));
    r  = p >>> SH_T[g];
    mx = (longint'(1) <<< (DW_T[g] - 1)) - 1;
    mn = -mx - 1;
    o  = (r > mx) || (r < mn);
    if (!o) d = r;
    else if (SAT_T[g] != 0) d = (r < 0) ? mn : mx;
    else d = (r <<< (64 - DW_T[g])) >>> (64 - DW_T[g]);
  endfunction

  task automatic chk(input string name, input int inst, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", name, inst, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
    logic [DW_T[gi]-1:0] d;
    logic                ir, ov, vo;
    longint              hd;
    bit                  ho, hold;
    longint              ed;
    bit                  eo;

    adpcm_main_mul_pipe_sat #(
      .ID(gi), .NUM_STAGE(NS_T[gi]), .din0_WIDTH(16), .din1_WIDTH(32),
      .dout_WIDTH(DW_T[gi]), .SHIFT(SH_T[gi]), .ROUND(RD_T[gi]), .SATURATE(SAT_T[gi])
    ) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .din0(din0), .din1(din1),
      .in_valid(in_valid), .in_ready(ir), .dout(d), .ovf(ov),
      .out_valid(vo), .out_ready(out_ready)
    );

    assign dout_x[gi]      = 64'($signed(d));
    assign ovf_x[gi]       = ov;
    assign out_valid_x[gi] = vo;
    assign in_ready_x[gi]  = ir;

    initial hold = 1'b0;

    // Sampled mid-cycle: these values decide the handshakes at the next rising edge.
    always @(negedge clk) begin
      if (reset) begin
        aq[gi].delete();
        bq[gi].delete();
        hold = 1'b0;
      end else begin
        chk("in_ready", gi, longint'(in_ready_x[gi]),
            longint'(ce && !(out_valid_x[gi] && !out_ready)));
        if (hold) begin
          chk("hold_valid", gi, longint'(out_valid_x[gi]), 1);
          chk("hold_dout", gi, dout_x[gi], hd);
          chk("hold_ovf", gi, longint'(ovf_x[gi]), longint'(ho));
        end
        if (ce && out_valid_x[gi] && out_ready) begin
          if (aq[gi].size() == 0) begin
            chk("spurious_out", gi, 1, 0);
          end else begin
            model(gi, aq[gi][0], bq[gi][0], ed, eo);
            void'(aq[gi].pop_front());
            void'(bq[gi].pop_front());
            chk("dout", gi, dout_x[gi], ed);
            chk("ovf", gi, longint'(ovf_x[gi]), longint'(eo));
          end
        end
        if (ce && in_valid && in_ready_x[gi]) begin
          aq[gi].push_back(longint'($signed(din0)));
          bq[gi].push_back(longint'($signed(din1)));
        end
        hold = out_valid_x[gi] && !(ce && out_ready);
        hd   = dout_x[gi];
        ho   = ovf_x[gi];
      end
    end
  end

  // One operand pair into empty pipes; records result and latency of every instance.
  task automatic single(input longint a, input longint b);
    for (int g = 0; g < NCFG; g++) got_lat[g] = 0;
    din0 = 16'(a);
    din1 = 32'(b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    ce = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      for (int g = 0; g < NCFG; g++) begin
        if (got_lat[g] == 0 && out_valid_x[g]) begin
          got_lat[g] = k;
          got_d[g]   = dout_x[g];
          got_o[g]   = ovf_x[g];
        end
      end
    end
    for (int g = 0; g < NCFG; g++) chk("latency", g, got_lat[g], NS_T[g]);
    $display("op %0d*%0d inst0 dout=%0d ovf=%0d lat=%0d", a, b, got_d[0], got_o[0], got_lat[0]);
  endtask

  initial begin
    int     idx;
    int     cnt;
    bit     acc;

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_valid", g, longint'(out_valid_x[g]), 0);
      chk("rst_dout", g, dout_x[g], 0);
      chk("rst_ovf", g, longint'(ovf_x[g]), 0);
    end
    reset = 1'b0;

    single(-3, 7);
    chk("t1_dout", 0, got_d[0], -21);
    chk("t1_ovf", 0, longint'(got_o[0]), 0);

    single(32767, 32767);
    chk("t2_wide", 0, got_d[0], 1073676289);
    chk("t2_sat_dout", 1, got_d[1], 32767);
    chk("t2_sat_ovf", 1, longint'(got_o[1]), 1);
    chk("t2_wrap_dout", 2, got_d[2], 1);
    chk("t2_wrap_ovf", 2, longint'(got_o[2]), 1);

    single(-32768, 32767);
    chk("t2_satneg_dout", 1, got_d[1], -32768);
    chk("t2_satneg_ovf", 1, longint'(got_o[1]), 1);

    single(5, 5);
    chk("t3_rnd_pos", 3, got_d[3], 2);
    single(-5, 5);
    chk("t3_rnd_neg", 3, got_d[3], -2);
    single(1, 8);
    chk("t3_rnd_half", 3, got_d[3], 1);
    chk("t3_trunc", 4, got_d[4], 0);
    chk("t3_rnd_sh3", 5, got_d[5], 1);

    // Back-to-back stream with out_ready dropped for three cycles.
    idx = 0;
    for (int c = 0; c < 100 && idx < 16; c++) begin
      din0 = 16'(idx * 1500 - 12000);
      din1 = 32'(idx * 777777 - 6000000);
      in_valid = 1'b1;
      out_ready = !(c >= 5 && c <= 7);
      @(negedge clk);
      acc = in_ready_x[0];
      if (c >= 5 && c <= 7) chk("t4_stall_ready", 0, longint'(in_ready_x[0]), 0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("t4_sent", 0, idx, 16);
    $display("stream with backpressure: %0d items sent", idx);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Stream with clock enable low for four cycles.
    idx = 0;
    for (int c = 0; c < 100 && idx < 12; c++) begin
      din0 = 16'(31000 - idx * 5000);
      din1 = 32'(idx * 123456789);
      in_valid = 1'b1;
      ce = !(c >= 4 && c <= 7);
      @(negedge clk);
      acc = in_ready_x[0];
      if (c >= 4 && c <= 7) chk("t5_ce_ready", 0, longint'(in_ready_x[0]), 0);
      @(posedge clk); #1;
      if (acc) idx++;
    end
    chk("t5_sent", 0, idx, 12);
    $display("stream with ce gap: %0d items sent", idx);
    in_valid = 1'b0;
    ce = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) begin
      din0 = 16'(100 + i);
      din1 = 32'(-200 - i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < NCFG; g++) begin
      chk("t6_valid", g, longint'(out_valid_x[g]), 0);
      chk("t6_dout", g, dout_x[g], 0);
    end
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      cnt += int'(out_valid_x[0]);
    end
    chk("t6_none_emerge", 0, cnt, 0);
    $display("reset flush: %0d late outputs", cnt);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      ce        = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        din0 = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7fff;
        din1 = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7fff_ffff;
      end else begin
        din0 = 16'($urandom);
        din1 = $urandom;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    ce = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) chk("drain_empty", g, aq[g].size(), 0);
    $display("random traffic done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
